// File: rtl/edit_mem_arb_pkg.sv
// Shared constants and return-pipe tag type for the edit memory arbiter.
// Also used by other schedulers that talk to the edit SRAM.
package edit_mem_arb_pkg;

   localparam int EDM_NUM_PORTS  = 4;
   localparam int EDM_ID_NBITS   = 2;
   localparam int EDM_DATA_NBITS = 32;
   localparam int EDM_ADDR_NBITS = 10;
   localparam int EDM_RD_LAT     = 2;
   localparam int EDM_CREDIT_MAX = 4;
   localparam int EDM_WR_MAX     = 4;

   typedef struct packed {
      logic [EDM_ID_NBITS-1:0] port_id;
      logic                    sop;
      logic                    eop;
   } edm_tag_type;

endpackage

// File: rtl/edit_mem_arb_if.sv
// Request, grant, SRAM and read-return signals of the edit memory arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface edit_mem_arb_if
   import edit_mem_arb_pkg::*;
#(
   parameter int NUM_PORTS  = EDM_NUM_PORTS,
   parameter int ID_NBITS   = EDM_ID_NBITS,
   parameter int DATA_NBITS = EDM_DATA_NBITS,
   parameter int ADDR_NBITS = EDM_ADDR_NBITS
) ();

   logic [NUM_PORTS-1:0]            rd_req;
   logic [NUM_PORTS*ADDR_NBITS-1:0] rd_addr;
   logic [NUM_PORTS-1:0]            rd_sop;
   logic [NUM_PORTS-1:0]            rd_eop;
   logic [NUM_PORTS-1:0]            rd_gnt;
   logic [NUM_PORTS-1:0]            credit_rel;
   logic                            wr_req;
   logic [ADDR_NBITS-1:0]           wr_addr;
   logic [DATA_NBITS-1:0]           wr_data;
   logic                            wr_gnt;
   logic                            mem_en;
   logic                            mem_we;
   logic [ADDR_NBITS-1:0]           mem_addr;
   logic [DATA_NBITS-1:0]           mem_wdata;
   logic [DATA_NBITS-1:0]           mem_rdata;
   logic                            ack;
   logic [ID_NBITS-1:0]             ack_port_id;
   logic                            ack_sop;
   logic                            ack_eop;
   logic [DATA_NBITS-1:0]           ack_rdata;
   logic                            credit_err;

   modport master (
      output rd_req, rd_addr, rd_sop, rd_eop, credit_rel,
      output wr_req, wr_addr, wr_data, mem_rdata,
      input  rd_gnt, wr_gnt, mem_en, mem_we, mem_addr, mem_wdata,
      input  ack, ack_port_id, ack_sop, ack_eop, ack_rdata, credit_err
   );

   modport slave (
      input  rd_req, rd_addr, rd_sop, rd_eop, credit_rel,
      input  wr_req, wr_addr, wr_data, mem_rdata,
      output rd_gnt, wr_gnt, mem_en, mem_we, mem_addr, mem_wdata,
      output ack, ack_port_id, ack_sop, ack_eop, ack_rdata, credit_err
   );

endinterface

// File: rtl/edit_mem_arb_rr_arb.sv
// Round-robin picker: first set request at or after ptr, one-hot out.
// Purely combinational so any scheduler can wrap its own pointer state.
module rr_arb #(
   parameter int N        = 4,
   parameter int ID_NBITS = 2
) (
   input  logic [N-1:0]        req,
   input  logic [ID_NBITS-1:0] ptr,
   output logic [N-1:0]        gnt
);

   logic [ID_NBITS-1:0] idx;
   logic                found;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         idx = ID_NBITS'((int'(ptr) + i) % N);
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/edit_mem_arb.sv
// Edit SRAM arbiter: one write port vs round-robin credited readers,
// burst locking, and a fixed-latency tagged read-return pipe.
module edit_mem_arb
   import edit_mem_arb_pkg::*;
#(
   parameter int NUM_PORTS  = EDM_NUM_PORTS,
   parameter int ID_NBITS   = EDM_ID_NBITS,
   parameter int DATA_NBITS = EDM_DATA_NBITS,
   parameter int ADDR_NBITS = EDM_ADDR_NBITS,
   parameter int RD_LAT     = EDM_RD_LAT,
   parameter int CREDIT_MAX = EDM_CREDIT_MAX,
   parameter int WR_MAX     = EDM_WR_MAX
) (
   input logic           clk,
   input logic           rst,
   edit_mem_arb_if.slave bus
);

   localparam int CW = $clog2(CREDIT_MAX + 1);
   localparam int RW = $clog2(WR_MAX + 1);

   logic [CW-1:0]        credit [NUM_PORTS];
   logic [NUM_PORTS-1:0] elig;
   logic [NUM_PORTS-1:0] arb_gnt;
   logic [NUM_PORTS-1:0] rd_gnt;
   logic [ID_NBITS-1:0]  rr_ptr;
   logic [ID_NBITS-1:0]  lock_id;
   logic [ID_NBITS-1:0]  gnt_id;
   logic                 lock;
   logic                 err_q;
   logic [RW-1:0]        wr_run;
   logic                 any_elig;
   logic                 wr_win;
   logic                 rd_win;
   logic                 iss_v;
   edm_tag_type          gnt_tag;
   edm_tag_type          iss_tag;
   logic                 pipe_v   [RD_LAT];
   edm_tag_type          pipe_tag [RD_LAT];
   logic                 ack;

   always_comb begin
      elig = '0;
      for (int p = 0; p < NUM_PORTS; p++)
         elig[p] = bus.rd_req[p]
                && (credit[p] < CW'(CREDIT_MAX))
                && (!lock || lock_id == ID_NBITS'(p));
   end

   rr_arb #(
      .N        (NUM_PORTS),
      .ID_NBITS (ID_NBITS)
   ) u_rr (
      .req (elig),
      .ptr (rr_ptr),
      .gnt (arb_gnt)
   );

   // Writes win unless they have starved an eligible reader for WR_MAX beats.
   assign any_elig = |elig;
   assign wr_win   = bus.wr_req && !rst
                  && !(wr_run == RW'(WR_MAX) && any_elig);
   assign rd_win   = any_elig && !rst && !wr_win;
   assign rd_gnt   = rd_win ? arb_gnt : '0;

   assign bus.rd_gnt = rd_gnt;
   assign bus.wr_gnt = wr_win;

   always_comb begin
      gnt_id = '0;
      for (int p = 0; p < NUM_PORTS; p++)
         if (arb_gnt[p]) gnt_id = ID_NBITS'(p);
   end

   assign gnt_tag = {gnt_id, bus.rd_sop[gnt_id], bus.rd_eop[gnt_id]};

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         iss_v         <= 1'b0;
         iss_tag       <= '0;
      end else begin
         bus.mem_en    <= wr_win || rd_win;
         bus.mem_we    <= wr_win;
         bus.mem_addr  <= wr_win ? bus.wr_addr
                          : bus.rd_addr[gnt_id*ADDR_NBITS +: ADDR_NBITS];
         bus.mem_wdata <= wr_win ? bus.wr_data : DATA_NBITS'(0);
         iss_v         <= rd_win;
         iss_tag       <= gnt_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int p = 0; p < NUM_PORTS; p++) credit[p] <= '0;
         err_q   <= 1'b0;
         rr_ptr  <= '0;
         lock    <= 1'b0;
         lock_id <= '0;
         wr_run  <= '0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (rd_gnt[p] && !bus.credit_rel[p])
               credit[p] <= credit[p] + 1'b1;
            else if (!rd_gnt[p] && bus.credit_rel[p] && credit[p] != '0)
               credit[p] <= credit[p] - 1'b1;
            if (bus.credit_rel[p] && credit[p] == '0)
               err_q <= 1'b1;
         end
         if (rd_win) begin
            rr_ptr <= (gnt_id == ID_NBITS'(NUM_PORTS - 1)) ? '0
                      : gnt_id + 1'b1;
            if (bus.rd_eop[gnt_id]) begin
               lock <= 1'b0;
            end else if (bus.rd_sop[gnt_id]) begin
               lock    <= 1'b1;
               lock_id <= gnt_id;
            end
         end
         if (wr_win)
            wr_run <= (wr_run == RW'(WR_MAX)) ? wr_run : wr_run + 1'b1;
         else
            wr_run <= '0;
      end
   end

   // Loaded from the issue register, so the tail lines up with SRAM data.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_v[i]   <= 1'b0;
            pipe_tag[i] <= '0;
         end
      end else begin
         pipe_v[0]   <= iss_v;
         pipe_tag[0] <= iss_tag;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_v[i]   <= pipe_v[i-1];
            pipe_tag[i] <= pipe_tag[i-1];
         end
      end
   end

   assign ack             = pipe_v[RD_LAT-1];
   assign bus.ack         = ack;
   assign bus.ack_port_id = pipe_tag[RD_LAT-1].port_id;
   assign bus.ack_sop     = pipe_tag[RD_LAT-1].sop;
   assign bus.ack_eop     = pipe_tag[RD_LAT-1].eop;
   assign bus.ack_rdata   = ack ? bus.mem_rdata : '0;
   assign bus.credit_err  = err_q;

endmodule

// File: tb/tb_edit_mem_arb.sv
// Directed bench for edit_mem_arb with a 2-cycle SRAM model whose
// default contents are 0xA0000000 | address.
module tb_edit_mem_arb;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_assert = 0;
   int   n_fail   = 0;
   int   exp_p;
   int   prev_p;
   logic [3:0] prev_oh;

   always #5 clk = ~clk;

   edit_mem_arb_if bus ();

   edit_mem_arb dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   logic [31:0] mem [1024];
   logic [31:0] rd1;
   logic [31:0] rd2;

   always @(posedge clk) begin
      if (rst) begin
         for (int a = 0; a < 1024; a++) mem[a] <= 32'hA000_0000 | a;
      end else if (bus.mem_en && bus.mem_we) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
      end
      if (bus.mem_en && !bus.mem_we) rd1 <= mem[bus.mem_addr];
      rd2 <= rd1;
   end

   assign bus.mem_rdata = rd2;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input int p, input logic [9:0] a,
                         input logic s, input logic e);
      bus.rd_addr[p*10 +: 10] = a;
      bus.rd_sop[p] = s;
      bus.rd_eop[p] = e;
   endtask

   initial begin
      bus.rd_req     = '0;
      bus.rd_addr    = '0;
      bus.rd_sop     = '0;
      bus.rd_eop     = '0;
      bus.credit_rel = '0;
      bus.wr_req     = 1'b1;
      bus.wr_addr    = '0;
      bus.wr_data    = '0;

      // reset state
      repeat (3) tick();
      #1;
      chk("rst_mem_en", bus.mem_en, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_ack", bus.ack, 0);
      chk("rst_err", bus.credit_err, 0);
      chk("rst_wr_gnt", bus.wr_gnt, 0);
      chk("rst_rd_gnt", bus.rd_gnt, 0);
      tick();
      rst = 1'b0;
      bus.wr_req = 1'b0;

      // 3-beat burst on port 0
      tick();
      set_rd(0, 10'd5, 1'b1, 1'b0);
      bus.rd_req = 4'b0001;
      #1;
      chk("b_gnt0", bus.rd_gnt, 4'b0001);
      tick();
      set_rd(0, 10'd6, 1'b0, 1'b0);
      #1;
      chk("b_gnt1", bus.rd_gnt, 4'b0001);
      chk("b_en1", bus.mem_en, 1);
      chk("b_addr1", bus.mem_addr, 5);
      tick();
      set_rd(0, 10'd7, 1'b0, 1'b1);
      #1;
      chk("b_gnt2", bus.rd_gnt, 4'b0001);
      chk("b_addr2", bus.mem_addr, 6);
      tick();
      bus.rd_req = '0;
      bus.credit_rel = 4'b0001;
      #1;
      chk("b_gnt3", bus.rd_gnt, 0);
      chk("b_addr3", bus.mem_addr, 7);
      chk("b_we3", bus.mem_we, 0);
      chk("b_ack0", bus.ack, 1);
      chk("b_id0", bus.ack_port_id, 0);
      chk("b_sop0", bus.ack_sop, 1);
      chk("b_eop0", bus.ack_eop, 0);
      chk("b_data0", bus.ack_rdata, 32'hA000_0005);
      tick();
      #1;
      chk("b_en4", bus.mem_en, 0);
      chk("b_ack1", bus.ack, 1);
      chk("b_sop1", bus.ack_sop, 0);
      chk("b_eop1", bus.ack_eop, 0);
      chk("b_data1", bus.ack_rdata, 32'hA000_0006);
      tick();
      #1;
      chk("b_ack2", bus.ack, 1);
      chk("b_eop2", bus.ack_eop, 1);
      chk("b_data2", bus.ack_rdata, 32'hA000_0007);
      tick();
      bus.credit_rel = '0;
      #1;
      chk("b_ack_end", bus.ack, 0);

      // rotation with all ports requesting; pointer sits at 1
      for (int p = 0; p < 4; p++) set_rd(p, 10'(16 + p), 1'b1, 1'b1);
      prev_oh = '0;
      prev_p  = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         bus.rd_req = 4'hF;
         bus.credit_rel = prev_oh;
         #1;
         exp_p = (1 + i) % 4;
         chk("rot_gnt", bus.rd_gnt, 4'b0001 << exp_p);
         if (i > 0) chk("rot_addr", bus.mem_addr, 16 + prev_p);
         if (i > 2) begin
            chk("rot_ack", bus.ack, 1);
            chk("rot_ack_id", bus.ack_port_id, (i - 2) % 4);
         end
         prev_oh = 4'b0001 << exp_p;
         prev_p  = exp_p;
      end
      tick();
      bus.rd_req = '0;
      bus.credit_rel = prev_oh;
      tick();
      bus.credit_rel = '0;
      repeat (4) tick();

      // credit exhaustion on port 1
      set_rd(1, 10'd40, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
         bus.rd_req = 4'b0010;
         #1;
         chk("cr_gnt", bus.rd_gnt, 4'b0010);
      end
      tick();
      #1;
      chk("cr_stall", bus.rd_gnt, 0);
      tick();
      bus.credit_rel = 4'b0010;
      #1;
      chk("cr_rel_cycle", bus.rd_gnt, 0);
      tick();
      bus.credit_rel = '0;
      #1;
      chk("cr_resume", bus.rd_gnt, 4'b0010);
      for (int i = 0; i < 4; i++) begin
         tick();
         bus.rd_req = '0;
         bus.credit_rel = 4'b0010;
      end
      tick();
      bus.credit_rel = '0;
      #1;
      chk("cr_err", bus.credit_err, 0);
      repeat (4) tick();

      // write burst against port 2 read
      set_rd(2, 10'd200, 1'b1, 1'b1);
      bus.wr_addr = 10'd200;
      bus.wr_data = 32'hDEAD_BEEF;
      for (int i = 0; i < 4; i++) begin
         tick();
         bus.wr_req = 1'b1;
         bus.rd_req = 4'b0100;
         #1;
         chk("wr_gnt", bus.wr_gnt, 1);
         chk("wr_rd_blk", bus.rd_gnt, 0);
         if (i > 0) chk("wr_mem_we", bus.mem_we, 1);
      end
      tick();
      #1;
      chk("wr_yield", bus.wr_gnt, 0);
      chk("wr_rd2", bus.rd_gnt, 4'b0100);
      tick();
      bus.rd_req = '0;
      #1;
      chk("wr_resume", bus.wr_gnt, 1);
      chk("wr_rd_en", bus.mem_en, 1);
      chk("wr_rd_we", bus.mem_we, 0);
      chk("wr_rd_addr", bus.mem_addr, 200);
      tick();
      bus.wr_req = 1'b0;
      #1;
      chk("wr_we_again", bus.mem_we, 1);
      tick();
      bus.credit_rel = 4'b0100;
      #1;
      chk("wr_ack", bus.ack, 1);
      chk("wr_ack_id", bus.ack_port_id, 2);
      chk("wr_ack_data", bus.ack_rdata, 32'hDEAD_BEEF);
      tick();
      bus.credit_rel = '0;
      repeat (4) tick();

      // burst lock on port 0 with port 3 waiting; pointer sits at 3
      set_rd(0, 10'd300, 1'b1, 1'b0);
      set_rd(3, 10'd400, 1'b1, 1'b1);
      tick();
      bus.rd_req = 4'b0001;
      #1;
      chk("lk_gnt0", bus.rd_gnt, 4'b0001);
      tick();
      set_rd(0, 10'd301, 1'b0, 1'b0);
      bus.rd_req = 4'b1001;
      #1;
      chk("lk_gnt1", bus.rd_gnt, 4'b0001);
      tick();
      set_rd(0, 10'd302, 1'b0, 1'b0);
      bus.wr_req = 1'b1;
      bus.wr_addr = 10'd500;
      #1;
      chk("lk_wr", bus.wr_gnt, 1);
      chk("lk_wr_rd", bus.rd_gnt, 0);
      tick();
      bus.wr_req = 1'b0;
      #1;
      chk("lk_gnt2", bus.rd_gnt, 4'b0001);
      chk("lk_we", bus.mem_we, 1);
      tick();
      set_rd(0, 10'd303, 1'b0, 1'b1);
      #1;
      chk("lk_gnt3", bus.rd_gnt, 4'b0001);
      tick();
      bus.rd_req = 4'b1000;
      #1;
      chk("lk_p3", bus.rd_gnt, 4'b1000);
      tick();
      bus.rd_req = '0;
      bus.credit_rel = 4'b1001;
      #1;
      chk("lk_p3_addr", bus.mem_addr, 400);
      for (int i = 0; i < 3; i++) begin
         tick();
         bus.credit_rel = 4'b0001;
      end
      tick();
      bus.credit_rel = '0;
      repeat (4) tick();

      // reset with two reads in flight
      set_rd(1, 10'd41, 1'b1, 1'b1);
      tick();
      bus.rd_req = 4'b0010;
      #1;
      chk("rs_gnt0", bus.rd_gnt, 4'b0010);
      tick();
      #1;
      chk("rs_gnt1", bus.rd_gnt, 4'b0010);
      tick();
      bus.rd_req = '0;
      rst = 1'b1;
      #1;
      chk("rs_en_pre", bus.mem_en, 1);
      tick();
      rst = 1'b0;
      #1;
      chk("rs_en_post", bus.mem_en, 0);
      chk("rs_ack0", bus.ack, 0);
      tick();
      #1;
      chk("rs_ack1", bus.ack, 0);
      tick();
      #1;
      chk("rs_ack2", bus.ack, 0);

      // release with no outstanding reads
      tick();
      bus.credit_rel = 4'b0100;
      #1;
      chk("ce_before", bus.credit_err, 0);
      tick();
      bus.credit_rel = '0;
      #1;
      chk("ce_set", bus.credit_err, 1);
      repeat (3) tick();
      #1;
      chk("ce_sticky", bus.credit_err, 1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("ce_cleared", bus.credit_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/edit_mem_arb.md
# edit_mem_arb

Arbiter and sequencer for the shared edit (PD chunk) memory. It grants one access per cycle among NUM_PORTS per-port read requesters and one PD write requester from the enqueue side. It enforces per-port outstanding-read credits so each editor per-port PD FIFO can never overflow. Read data returns after a fixed latency, tagged with port id and sop/eop, and sits between the editor's edit_mem_req/ack interface and the single-port edit SRAM.

## Interface
- NUM_PORTS, `NUM_OF_PORTS: number of read requesters
- ID_NBITS, `PORT_ID_NBITS: port id width
- DATA_NBITS, `DATA_PATH_NBITS: memory word width
- ADDR_NBITS, 10: memory word address width
- RD_LAT, 2: SRAM read latency, cycles from mem_en to valid mem_rdata (1..4)
- CREDIT_MAX, 4: max outstanding reads per port (equals consumer FIFO depth)
- WR_MAX, 4: max consecutive write grants while a read is eligible
- clk  in  1  clock
- `RESET_SIG  in  1  synchronous, active-high reset
- rd_req  in  NUM_PORTS  per-port read request, held until granted
- rd_addr  in  NUM_PORTS*ADDR_NBITS  per-port read address, port p at [p*ADDR_NBITS +: ADDR_NBITS]
- rd_sop, rd_eop  in  NUM_PORTS each  burst first/last beat flags
- rd_gnt  out  NUM_PORTS  one-hot read grant (combinational)
- credit_rel  in  NUM_PORTS  consumer popped one word for port p
- wr_req  in  1  write request; wr_addr  in  ADDR_NBITS; wr_data  in  DATA_NBITS
- wr_gnt  out  1  write grant (combinational)
- mem_en, mem_we  out  1  registered SRAM enable / write enable
- mem_addr  out  ADDR_NBITS; mem_wdata  out  DATA_NBITS  registered
- mem_rdata  in  DATA_NBITS  SRAM read data
- ack  out  1  read data valid; ack_port_id  out  ID_NBITS; ack_sop, ack_eop  out  1; ack_rdata  out  DATA_NBITS
- credit_err  out  1  sticky: credit_rel seen with zero outstanding

## Operation
- Read eligibility of port p: rd_req[p] & (credit[p] < CREDIT_MAX) & (no burst lock, or lock owner == p).
- Grant priority per cycle: a pending write wins unless wr_run == WR_MAX and some read is eligible, in which case the read wins. wr_run counts consecutive write grants and clears on any read grant or on a cycle with no write grant.
- Read selection is round-robin over eligible ports, starting at rr_ptr. After a read grant to p, rr_ptr = p+1 mod NUM_PORTS.
- Burst lock: a read grant with rd_sop & ~rd_eop locks reads to that port. The lock clears on its granted rd_eop beat. Writes may still interleave. The requester must hold rd_req through eop; while locked, other reads get no grant.
- Credits: credit[p] += read grant to p, -= credit_rel[p]. Simultaneous grant and release leaves credit unchanged. Release at 0 leaves credit at 0 and sets credit_err.
- Return pipe: RD_LAT-deep shift register of {valid, port id, sop, eop}, loaded on read issue. ack_rdata = mem_rdata passed through unregistered when ack is asserted.

## Timing
- Grant is in cycle T, combinational from inputs and state. mem_* are registered in T+1. ack, tag and data appear in T+1+RD_LAT.
- Throughput is one access per cycle. A port at credit CREDIT_MAX stalls until a credit_rel.
- Reset values: every output 0, credit 0, rr_ptr 0, lock clear, wr_run 0, return pipe empty, credit_err 0.
- Reset mid-operation drops in-flight reads: no ack for them.
- mem_en is low in cycles with no grant. mem_we = 1 only for a write.

## Structure
- Shared package (meta_package): EDM_RD_LAT and EDM_CREDIT_MAX constants, and a typedef edm_tag_type {port_id, sop, eop} for the return pipe.
- One sub-module, rr_arb (NUM_PORTS-wide round-robin with pointer input and one-hot output), reusable by other schedulers.

## Test plan
- Single port 0: 3-beat burst at addresses 5, 6, 7 with sop/eop, RD_LAT=2 -> mem_en at T+1..T+3; ack with id 0, data of 5, 6, 7, ack_sop on first beat, ack_eop on last, at T+3..T+5.
- All ports requesting single beats continuously with immediate credit_rel -> grants rotate 0, 1, 2, 3, 0…, none skipped.
- Port 1 issues 4 reads with no credit_rel -> 5th request not granted; one credit_rel -> granted the next cycle.
- wr_req held high with port 2 read pending, WR_MAX=4 -> 4 write grants, then 1 read grant to port 2, then writes resume.
- Port 0 locked in a 4-beat burst while port 3 requests -> port 3 granted only after the port-0 eop grant; a write mid-burst is granted without breaking the lock.
- Reset asserted with 2 reads in flight -> no ack after reset. credit_rel at credit 0 -> credit_err=1 and stays 1 until reset.
